pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline; drives enable/flush of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards in ID.
- Redirects and flushes on taken branches resolved in MEM.
- Freezes the pipe while data memory is not ready, with a timeout watchdog.

---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/pipe_hazard_ctrl_loaduse.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Optional perf counters in pipe_hazard_ctrl are enabled by PIPE_HAZARD_PERF_EN.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         TIMEOUT_DEF = 15;

    typedef struct packed {
        logic pc_en;
        logic pc_src;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } ctrl_t;

    // Whole pipe held; only the MEM/WB slot is turned into a bubble.
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c             = '0;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_loaduse.sv
// Combinational load-use hazard compare between the load in ID/EX and the
// source registers of the instruction in IF/ID.
module loaduse_detect
    import pipe_pkg::*;
(
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    output logic       hazard_o
);

    // $zero never carries a real dependency, so a load into it never stalls.
    assign hazard_o = ex_memread_i && (ex_rt_i != REG_ZERO) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// redirect flushes, dmem wait freeze with watchdog. Macro PIPE_HAZARD_PERF_EN adds perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        mem_branch,
    input  logic        mem_zero,
    input  logic        mem_access,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        pc_src,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        timeout_err,
    output logic [1:0]  dbg_state
`ifdef PIPE_HAZARD_PERF_EN
   ,output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
    output logic [31:0] loaduse_events
`endif
);

    state_e        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          terr_q, terr_d;
    logic          lu_hazard, dstall, taken;
    ctrl_t         run_c, ctrl;

    loaduse_detect u_loaduse (
        .ex_memread_i (ex_memread),
        .ex_rt_i      (ex_rt),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_uses_rt_i (id_uses_rt),
        .hazard_o     (lu_hazard)
    );

    assign dstall = mem_access && !dmem_ready;
    assign taken  = mem_branch && mem_zero;

    // Normal-running decode; also reused on the cycle a dmem wait completes.
    always_comb begin
        run_c = '0;
        if (dstall) begin
            run_c = ctrl_freeze();
        end else if (taken) begin
            run_c.pc_en       = 1'b1;
            run_c.pc_src      = 1'b1;
            run_c.ifid_flush  = 1'b1;
            run_c.idex_flush  = 1'b1;
            run_c.exmem_flush = 1'b1;
            run_c.memwb_en    = 1'b1;
        end else if (lu_hazard) begin
            run_c.idex_flush = 1'b1;
            run_c.exmem_en   = 1'b1;
            run_c.memwb_en   = 1'b1;
        end else begin
            run_c.pc_en    = 1'b1;
            run_c.ifid_en  = 1'b1;
            run_c.idex_en  = 1'b1;
            run_c.exmem_en = 1'b1;
            run_c.memwb_en = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        terr_d  = terr_q;
        ctrl    = '0;
        case (state_q)
            ST_INIT: begin
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_flush  = 1'b1;
                ctrl.exmem_flush = 1'b1;
                ctrl.memwb_flush = 1'b1;
                state_d          = ST_RUN;
            end
            ST_RUN: begin
                ctrl = run_c;
                if (dstall) begin
                    state_d = ST_WAIT;
                    wcnt_d  = CW'(1);
                end
            end
            ST_WAIT: begin
                if (dmem_ready) begin
                    ctrl    = run_c;
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end else begin
                    ctrl = ctrl_freeze();
                    if (wcnt_q == CW'(TIMEOUT)) begin
                        state_d = ST_ERR;
                        terr_d  = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + CW'(1);
                    end
                end
            end
            ST_ERR: begin
                ctrl   = ctrl_freeze();
                terr_d = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            wcnt_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            terr_q  <= terr_d;
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign pc_src      = ctrl.pc_src;
    assign ifid_en     = ctrl.ifid_en;
    assign idex_en     = ctrl.idex_en;
    assign exmem_en    = ctrl.exmem_en;
    assign memwb_en    = ctrl.memwb_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign memwb_flush = ctrl.memwb_flush;
    assign timeout_err = terr_q;
    assign dbg_state   = state_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_q, flush_q, lu_q;
    logic        active;

    // A load-use bubble is the only active-state decode with idex_flush set and the PC held.
    assign active = (state_q == ST_RUN) || (state_q == ST_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
            lu_q    <= '0;
        end else begin
            if (active && !ctrl.pc_en)                   stall_q <= sat_inc(stall_q);
            if (ctrl.pc_src)                             flush_q <= sat_inc(flush_q);
            if (active && ctrl.idex_flush && !ctrl.pc_en) lu_q   <= sat_inc(lu_q);
        end
    end

    assign stall_cycles   = stall_q;
    assign flush_events   = flush_q;
    assign loaduse_events = lu_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random
// stimulus against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_memread, mem_branch, mem_zero, mem_access, dmem_ready;
  logic pc_en, pc_src, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, timeout_err;
  logic [1:0] dbg_state;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_events, loaduse_events;
`endif

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  // model state: post-reset cycle pending, consecutive frozen cycles, watchdog tripped
  bit m_init;
  int m_stalls;
  bit m_err;
  int m_stall_cnt, m_flush_cnt, m_lu_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TO), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .pc_src(pc_src),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
`ifdef PIPE_HAZARD_PERF_EN
   ,.stall_cycles(stall_cycles), .flush_events(flush_events), .loaduse_events(loaduse_events)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // stage action: 2 = cleared to bubble, 1 = loads, 0 = holds
  function automatic logic [1:0] act(input logic fl, input logic en);
    return fl ? 2'd2 : (en ? 2'd1 : 2'd0);
  endfunction

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_rt = 5'd0;
    mem_branch = 1'b0; mem_zero = 1'b0;
    mem_access = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic set_loaduse(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                             input logic [4:0] lrt);
    id_rs = rs; id_rt = rt; id_uses_rt = use_rt; ex_memread = 1'b1; ex_rt = lrt;
  endtask

  task automatic set_random();
    id_rs = 5'($urandom_range(0, 3));
    id_rt = 5'($urandom_range(0, 3));
    id_uses_rt = 1'($urandom_range(0, 1));
    ex_memread = 1'($urandom_range(0, 1));
    ex_rt = 5'($urandom_range(0, 3));
    mem_branch = ($urandom_range(0, 3) == 0);
    mem_zero = 1'($urandom_range(0, 1));
    mem_access = ($urandom_range(0, 3) == 0);
    dmem_ready = ($urandom_range(0, 2) != 0);
  endtask

  // Check outputs for the current cycle against the model, then advance one clock.
  task automatic tick();
    logic e_pc_en, e_pc_src, hz, taken, freeze, lu_sel;
    logic [1:0] a_if, a_id, a_ex, a_wb, e_state;
    #2;
    if (!rst) begin
      m_init = 1'b1; m_stalls = 0; m_err = 1'b0;
      m_stall_cnt = 0; m_flush_cnt = 0; m_lu_cnt = 0;
    end
    hz = ex_memread && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    taken = mem_branch && mem_zero;
    freeze = m_err || (!m_init && !dmem_ready && ((m_stalls > 0) || mem_access));
    e_pc_en = 1'b0; e_pc_src = 1'b0; lu_sel = 1'b0;
    if (m_init) begin
      a_if = 2; a_id = 2; a_ex = 2; a_wb = 2;
    end else if (freeze) begin
      a_if = 0; a_id = 0; a_ex = 0; a_wb = 2;
    end else if (taken) begin
      e_pc_en = 1'b1; e_pc_src = 1'b1;
      a_if = 2; a_id = 2; a_ex = 2; a_wb = 1;
    end else if (hz) begin
      lu_sel = 1'b1;
      a_if = 0; a_id = 2; a_ex = 1; a_wb = 1;
    end else begin
      e_pc_en = 1'b1;
      a_if = 1; a_id = 1; a_ex = 1; a_wb = 1;
    end
    e_state = m_err ? 2'd3 : m_init ? 2'd0 : (m_stalls > 0) ? 2'd2 : 2'd1;
    exp_q.push_back({30'd0, e_pc_en, e_pc_src});
    exp_q.push_back({24'd0, a_if, a_id, a_ex, a_wb});
    exp_q.push_back({31'd0, m_err});
    exp_q.push_back({30'd0, e_state});
    check_eq("pc", {pc_en, pc_src}, exp_q.pop_front());
    check_eq("stages", {act(ifid_flush, ifid_en), act(idex_flush, idex_en),
                        act(exmem_flush, exmem_en), act(memwb_flush, memwb_en)}, exp_q.pop_front());
    check_eq("terr", timeout_err, exp_q.pop_front());
    check_eq("state", dbg_state, exp_q.pop_front());
`ifdef PIPE_HAZARD_PERF_EN
    check_eq("stall_cnt", stall_cycles, m_stall_cnt);
    check_eq("flush_cnt", flush_events, m_flush_cnt);
    check_eq("lu_cnt", loaduse_events, m_lu_cnt);
`endif
    if (rst) begin
      if (!m_init && !m_err) begin
        if (!e_pc_en) m_stall_cnt++;
        if (e_pc_src) m_flush_cnt++;
        if (lu_sel) m_lu_cnt++;
      end
      if (m_err) begin
        m_err = 1'b1;
      end else if (m_init) begin
        m_init = 1'b0;
      end else if (freeze) begin
        m_stalls++;
        if (m_stalls == TO + 1) m_err = 1'b1;
      end else begin
        m_stalls = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    #1;
    do_reset();
    tick();

    // load-use via rs, then via rt, then a taken branch
    set_loaduse(5'd8, 5'd3, 1'b0, 5'd8); tick();
    set_idle(); tick();
    set_loaduse(5'd4, 5'd9, 1'b1, 5'd9); tick();
    set_idle(); tick();
    mem_branch = 1'b1; mem_zero = 1'b1; tick();
    set_idle(); tick();
`ifdef PIPE_HAZARD_PERF_EN
    check_eq("perf_lu", loaduse_events, 32'd2);
    check_eq("perf_flush", flush_events, 32'd1);
    check_eq("perf_stall", stall_cycles, 32'd2);
`endif

    // load into $zero and not-taken branch: no action
    set_loaduse(5'd0, 5'd0, 1'b1, 5'd0); tick();
    set_idle(); mem_branch = 1'b1; mem_zero = 1'b0; tick();
    set_idle(); tick();

    // 3 wait cycles with a concurrent load-use, then ready
    mem_access = 1'b1; dmem_ready = 1'b0; set_loaduse(5'd5, 5'd0, 1'b0, 5'd5);
    for (int i = 0; i < 3; i++) tick();
    set_idle(); mem_access = 1'b1; dmem_ready = 1'b1; tick();
    set_idle(); tick();

    // branch held through a wait is taken on the ready cycle
    mem_access = 1'b1; dmem_ready = 1'b0; mem_branch = 1'b1; mem_zero = 1'b1; tick();
    dmem_ready = 1'b1; tick();
    set_idle(); tick();

    // watchdog
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < TO + 1; i++) tick();
    check_eq("terr_rise", timeout_err, 32'd1);
    check_eq("err_state", dbg_state, 32'd3);
    for (int i = 0; i < 5; i++) begin set_random(); tick(); end
    set_idle();
    do_reset();

    // reset asserted mid-wait
    mem_access = 1'b1; dmem_ready = 1'b0; tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("async_rst", dbg_state, 32'd0);
    tick();
    rst = 1'b1; set_idle(); tick(); tick();

    for (int i = 0; i < 3000; i++) begin
      set_random();
      rst = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
